// File: rtl/fetch_queue_if.sv
// Fetch-stage buses: sequential instruction-memory port
// and the head-of-queue view presented to decode.
interface fetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             if_valid;
    logic [INS_W-1:0] if_instr;
    logic [PC_W-1:0]  if_pc;

    modport master (
        output imem_req,
        output imem_addr,
        output if_valid,
        output if_instr,
        output if_pc,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-limited sequential fetch into a
// small prefetch queue, with redirect flush of buffered/in-flight words.
module fetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    fetch_queue_if.master   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PC_W-1:0] STEP = PC_W'(4);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  rsp_pc;
    logic [PC_W-1:0]  q_pc  [DEPTH];
    logic [INS_W-1:0] q_ins [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop;

    logic          has_credit;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight_acc;

    // Outstanding plus buffered never exceeds DEPTH, so a push always fits.
    assign has_credit = (int'(count) + int'(inflight)) < DEPTH;

    assign bus.imem_req  = reset & ~redirect & has_credit;
    assign bus.imem_addr = fetch_pc;

    assign bus.if_valid = (count != '0);
    assign bus.if_instr = q_ins[rd_ptr];
    assign bus.if_pc    = q_pc[rd_ptr];

    // A response with nothing outstanding is a protocol error: ignore it.
    assign grant = bus.imem_req & bus.imem_gnt;
    assign rsp   = bus.imem_rvalid & (inflight != '0);
    assign push  = rsp & ~redirect & (drop == '0);
    assign pop   = bus.if_valid & ~stall & ~redirect;

    assign inflight_acc = inflight - CW'(rsp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            rsp_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]  <= '0;
                q_ins[i] <= '0;
            end
        end else if (redirect) begin
            // Every fetch still outstanding belongs to the old stream.
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight_acc;
            drop     <= inflight_acc;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + STEP;
            end
            inflight <= inflight_acc + CW'(grant);
            if (rsp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (push) begin
                q_pc[wr_ptr]  <= rsp_pc;
                q_ins[wr_ptr] <= bus.imem_rdata;
                wr_ptr        <= wr_ptr + AW'(1);
                rsp_pc        <= rsp_pc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner sequences and
// randomized traffic against a queue-level reference model.
module tb_fetch_queue;
    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            stall = 1'b0;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    fetch_queue #(
        .PC_W(PC_W),
        .INS_W(INS_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .bus(bus)
    );

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            stale;
    } pend_t;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } ent_t;

    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } mreq_t;

    typedef struct {
        logic            rd;
        logic [PC_W-1:0] rpc;
        logic            req;
        logic [PC_W-1:0] addr;
        logic            v;
        logic [PC_W-1:0] pc;
    } vec_t;

    // reference model: decoded instructions waiting and fetches outstanding
    ent_t            fq[$];
    pend_t           pend[$];
    logic [PC_W-1:0] m_fetch = '0;

    // memory model
    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned gnt_pct = 100;
    logic        spur = 1'b0;

    logic             g_c;
    logic             rv_c;
    logic [INS_W-1:0] rd_c;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [INS_W-1:0] ftag(input logic [PC_W-1:0] a);
        return 32'hA500_0000 | INS_W'(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s @cyc %0d: bound expired", nm, cyc);
    endtask

    task automatic check_model();
        logic ereq;
        ereq = reset && !redirect && (fq.size() + pend.size() < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(ereq));
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_fetch));
        chk("if_valid", 32'(bus.if_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("if_pc", 32'(bus.if_pc), 32'(fq[0].pc));
            chk("if_instr", bus.if_instr, fq[0].ins);
        end
    endtask

    task automatic pre();
        g_c  = ($urandom_range(99, 0) < gnt_pct);
        rv_c = 1'b0;
        rd_c = '0;
        if (spur) begin
            rv_c = 1'b1;
            rd_c = 32'hDEAD_BEEF;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            rv_c = 1'b1;
            rd_c = ftag(mq[0].addr);
        end
        bus.imem_gnt    = g_c;
        bus.imem_rvalid = rv_c;
        bus.imem_rdata  = rd_c;
        @(negedge clk);
        check_model();
    endtask

    task automatic post();
        logic  ereq;
        pend_t p;
        int    due;
        ereq = reset && !redirect && (fq.size() + pend.size() < DEPTH);
        if (rv_c && !spur && mq.size() != 0) begin
            void'(mq.pop_front());
        end
        if (bus.imem_req && g_c) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{bus.imem_addr, due});
        end
        if (reset) begin
            if (fq.size() != 0 && !stall && !redirect) begin
                void'(fq.pop_front());
            end
            if (rv_c && pend.size() != 0) begin
                p = pend.pop_front();
                if (!p.stale && !redirect) fq.push_back('{p.pc, rd_c});
            end
            if (ereq && g_c) begin
                pend.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + PC_W'(4);
            end
            if (redirect) begin
                fq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_fetch = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle_step();
        pre();
        post();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t            tbl[12];
        logic [PC_W-1:0] held;
        logic            found;

        // redirect, redirect_pc, exp req, exp addr, exp valid, exp pc
        tbl[0]  = '{1'b0, 9'h000, 1'b1, 9'h000, 1'b0, 9'h000};
        tbl[1]  = '{1'b0, 9'h000, 1'b1, 9'h004, 1'b0, 9'h000};
        tbl[2]  = '{1'b0, 9'h000, 1'b1, 9'h008, 1'b1, 9'h000};
        tbl[3]  = '{1'b0, 9'h000, 1'b1, 9'h00C, 1'b1, 9'h004};
        tbl[4]  = '{1'b0, 9'h000, 1'b1, 9'h010, 1'b1, 9'h008};
        tbl[5]  = '{1'b1, 9'h1F8, 1'b0, 9'h014, 1'b1, 9'h00C};
        tbl[6]  = '{1'b0, 9'h000, 1'b1, 9'h1F8, 1'b0, 9'h000};
        tbl[7]  = '{1'b0, 9'h000, 1'b1, 9'h1FC, 1'b0, 9'h000};
        tbl[8]  = '{1'b0, 9'h000, 1'b1, 9'h000, 1'b1, 9'h1F8};
        tbl[9]  = '{1'b0, 9'h000, 1'b1, 9'h004, 1'b1, 9'h1FC};
        tbl[10] = '{1'b0, 9'h000, 1'b1, 9'h008, 1'b1, 9'h000};
        tbl[11] = '{1'b0, 9'h000, 1'b1, 9'h00C, 1'b1, 9'h004};

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_pc", 32'(bus.if_pc), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // startup latency, steady flow, redirect with PC wrap
        for (int i = 0; i < 12; i++) begin
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            pre();
            chk($sformatf("tbl%0d_req", i), 32'(bus.imem_req),
                32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), 32'(bus.imem_addr),
                32'(tbl[i].addr));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.if_valid),
                32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_pc", i), 32'(bus.if_pc),
                    32'(tbl[i].pc));
                chk($sformatf("tbl%0d_instr", i), bus.if_instr,
                    ftag(tbl[i].pc));
            end
            post();
        end
        redirect = 1'b0;

        // decode stall: head holds, credits run out
        stall = 1'b1;
        held  = bus.if_pc;
        for (int i = 0; i < 8; i++) begin
            pre();
            chk("stall_hold_pc", 32'(bus.if_pc), 32'(held));
            if (i == 7) chk("stall_full_req", 32'(bus.imem_req), 32'd0);
            post();
        end
        stall = 1'b0;
        for (int i = 0; i < 8; i++) cycle_step();

        // redirect with two fetches in flight, 2-cycle memory
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20 && pend.size() != 2; i++) cycle_step();
        if (pend.size() != 2) timeout("redir_setup");
        redirect    = 1'b1;
        redirect_pc = 9'h040;
        cycle_step();
        redirect = 1'b0;
        pre();
        chk("redir_next_req", 32'(bus.imem_req), 32'd1);
        chk("redir_next_addr", 32'(bus.imem_addr), 32'h040);
        post();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            pre();
            if (bus.if_valid) begin
                found = 1'b1;
                chk("redir_first_pc", 32'(bus.if_pc), 32'h040);
            end
            post();
        end
        if (!found) timeout("redir_first_valid");

        // grant withheld: address holds until the grant
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 6; i++) cycle_step();
        gnt_pct = 0;
        held = bus.imem_addr;
        for (int i = 0; i < 3; i++) begin
            pre();
            chk("nognt_req", 32'(bus.imem_req), 32'd1);
            chk("nognt_addr", 32'(bus.imem_addr), 32'(held));
            post();
        end
        gnt_pct = 100;
        pre();
        chk("gnt_addr", 32'(bus.imem_addr), 32'(held));
        post();
        pre();
        chk("gnt_addr_next", 32'(bus.imem_addr), 32'(held + PC_W'(4)));
        post();

        // async reset with 3 queued and 1 in flight
        stall = 1'b1;
        for (int i = 0; i < 30 && !(fq.size() == 3 && pend.size() == 1);
             i++) begin
            cycle_step();
        end
        if (!(fq.size() == 3 && pend.size() == 1)) timeout("rst_setup");
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.if_valid), 32'd0);
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_pc", 32'(bus.if_pc), 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'd0);
        fq.delete();
        pend.delete();
        mq.delete();
        m_fetch = '0;
        stall   = 1'b0;
        gnt_pct = 0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        spur  = 1'b1;
        cycle_step();
        spur    = 1'b0;
        gnt_pct = 100;
        pre();
        chk("rel_valid", 32'(bus.if_valid), 32'd0);
        chk("rel_req", 32'(bus.imem_req), 32'd1);
        chk("rel_addr", 32'(bus.imem_addr), 32'h000);
        post();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            pre();
            if (bus.if_valid) begin
                found = 1'b1;
                chk("rel_first_pc", 32'(bus.if_pc), 32'h000);
                chk("rel_first_instr", bus.if_instr, ftag(9'h000));
            end
            post();
        end
        if (!found) timeout("rel_first_valid");

        // randomized traffic against the model
        lat_min = 1;
        lat_max = 3;
        gnt_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(99, 0) < 30);
            redirect = ($urandom_range(99, 0) < 4);
            redirect_pc = PC_W'($urandom) & ~PC_W'(3);
            spur = (pend.size() == 0 && mq.size() == 0 &&
                    $urandom_range(99, 0) < 5);
            cycle_step();
        end
        spur     = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a small prefetch queue. It sits directly upstream of the IF/ID pipeline register. It issues sequential word requests to a variable-latency instruction memory and buffers the returned instructions with their PCs. It presents one instruction per cycle to the decode stage, honours the hazard-unit stall, and on a taken branch/jump redirect it flushes buffered and in-flight fetches.

## Interface
Parameters:
- PC_W, 9, program counter / instruction address width (byte address)
- INS_W, 32, instruction width
- DEPTH, 4, queue entries; also the maximum number of outstanding plus buffered fetches (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (low = in reset)
- redirect  in  1  taken branch/jump from EX (PcSel); has priority over everything
- redirect_pc  in  PC_W  new fetch target, sampled when redirect=1
- stall  in  1  decode stall (load-use hazard); blocks dequeue
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  fetch address
- imem_gnt  in  1  memory accepts request this cycle (handshake = imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  INS_W  response instruction
- if_valid  out  1  queue head valid
- if_instr  out  INS_W  queue head instruction
- if_pc  out  PC_W  queue head PC

## Operation
- State: fetch_pc, rsp_pc (PC_W); queue of DEPTH × {pc, instr}, with rd/wr pointers and count; inflight and drop counters, each clog2(DEPTH+1) bits.
- Credit rule: imem_req = reset & !redirect & (count + inflight < DEPTH). Hence a push can never overflow the queue.
- imem_addr = fetch_pc. While imem_req=1 and imem_gnt=0, imem_addr is held stable.
- On grant: fetch_pc += 4, wrapping modulo 2^PC_W; inflight += 1.
- On imem_rvalid: inflight -= 1.
  - If drop > 0: the response is discarded and drop -= 1.
  - Otherwise {rsp_pc, imem_rdata} is pushed and rsp_pc += 4 (wrap).
- Dequeue when if_valid & !stall & !redirect. Push and pop in the same cycle leave count unchanged.
- if_valid = (count != 0). if_instr and if_pc come from the head entry, combinationally from registers.
- Redirect, in the cycle redirect=1:
  - no request is issued;
  - no dequeue;
  - a response arriving this cycle is discarded;
  - next state: count=0, pointers=0, fetch_pc=rsp_pc=redirect_pc, drop = inflight after this cycle's response accounting (all in-flight fetches are stale).
- A new redirect while drop > 0 recomputes drop from inflight. Correctness holds because responses are in order.
- imem_rvalid with inflight=0 is a protocol error; it is ignored with no state change.
- No combinational path from imem_rvalid or imem_rdata to the if_* outputs.

## Timing
- Reset (async assert, low): fetch_pc=0, rsp_pc=0, count=inflight=drop=0. Outputs: imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0.
- Reset assertion mid-operation clears the state immediately. Buffered and in-flight fetches are lost, and responses after reset release with inflight=0 are ignored.
- Latency with a 1-cycle memory and gnt=1:
  - request granted in cycle T;
  - rvalid in T+1;
  - if_valid with that instruction in T+2.
- Steady state is one instruction per cycle.
- After redirect in cycle R: imem_addr=redirect_pc with imem_req=1 in R+1. With a 1-cycle memory, the first valid post-redirect instruction appears in R+3.
- Full (count+inflight=DEPTH): imem_req=0 until a dequeue frees a credit. imem_req re-asserts the cycle after the dequeue.
- Empty: if_valid=0. A stall during empty has no effect.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning addr-tagged words: imem_addr 0x000, 0x004, 0x008…; first if_valid 2 cycles after the first grant with if_pc=0x000; then one consecutive PC per cycle.
- Hold stall=1 for 8 cycles in steady flow: count+inflight reaches 4 and imem_req drops to 0; if_pc stays constant. On release, PCs continue in order with no gap or duplicate.
- Redirect to 0x040 with 2 requests in flight (2-cycle memory): both stale responses are dropped; the next if_valid shows if_pc=0x040; imem_addr=0x040 in the cycle after redirect.
- imem_gnt=0 for 3 cycles with imem_req=1: imem_addr is stable; fetch_pc advances only on the grant cycle.
- Redirect to 0x1F8: fetched PCs are 0x1F8, 0x1FC, 0x000, 0x004 (wrap), with matching if_pc.
- Assert reset low mid-cycle with 3 queued and 1 in flight: if_valid and imem_req drop to 0 immediately. After release, a late rvalid is ignored and fetch restarts at 0x000.
